// File: rtl/vxe_fifo2_pkg.sv
// Shared types for the vxe_fifo2 queue: decoded per-cycle operation and its decoder.
package vxe_fifo2_pkg;

    typedef enum logic [1:0] {
        OpNone  = 2'b00,
        OpRead  = 2'b01,
        OpWrite = 2'b10,
        OpBoth  = 2'b11
    } fifo_op_e;

    function automatic fifo_op_e fifo_op(input logic wr_ok, input logic rd_ok);
        return fifo_op_e'({wr_ok, rd_ok});
    endfunction

endpackage

// File: rtl/vxe_fifo2_mem.sv
// Register array for vxe_fifo2: synchronous write, asynchronous read, cleared on reset.
module vxe_fifo2_mem #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH_POW2 = 2
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic                  we_i,
    input  logic [DEPTH_POW2-1:0] waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [DEPTH_POW2-1:0] raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    localparam int unsigned Depth = 2 ** DEPTH_POW2;

    logic [DATA_WIDTH-1:0] mem_q [Depth];

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            for (int unsigned i = 0; i < Depth; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/vxe_fifo2.sv
// Single-clock show-ahead FIFO with full/empty/one-entry flags and synchronous soft reset.
module vxe_fifo2
    import vxe_fifo2_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH_POW2 = 2,
    parameter int unsigned USE_EMPTY1 = 0
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    input  logic                  wr,
    input  logic                  rd,
    input  logic                  srst,
    output logic                  full,
    output logic                  empty1,
    output logic                  empty
);

    localparam int unsigned Depth = 2 ** DEPTH_POW2;
    localparam int unsigned CntW  = DEPTH_POW2 + 1;
    localparam logic [CntW-1:0] DepthCnt = CntW'(Depth);

    logic [DEPTH_POW2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_POW2-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]       count_q, count_d;
    logic                  rd_ok, wr_ok, mem_we;
    fifo_op_e              op;

    assign empty = (count_q == '0);
    assign full  = (count_q == DepthCnt);

    if (USE_EMPTY1 != 0) begin : g_empty1
        assign empty1 = (count_q == CntW'(1));
    end else begin : g_no_empty1
        assign empty1 = 1'b0;
    end

    // A full FIFO still accepts a write when the head is popped in the same cycle.
    assign rd_ok  = rd & ~empty;
    assign wr_ok  = wr & (~full | rd_ok);
    assign op     = fifo_op(wr_ok, rd_ok);
    assign mem_we = wr_ok & ~srst;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (srst) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (wr_ok) wr_ptr_d = wr_ptr_q + 1'b1;
            if (rd_ok) rd_ptr_d = rd_ptr_q + 1'b1;
            unique case (op)
                OpWrite: count_d = count_q + 1'b1;
                OpRead:  count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    vxe_fifo2_mem #(
        .DATA_WIDTH(DATA_WIDTH),
        .DEPTH_POW2(DEPTH_POW2)
    ) u_mem (
        .clk    (clk),
        .nrst   (nrst),
        .we_i   (mem_we),
        .waddr_i(wr_ptr_q),
        .wdata_i(data_in),
        .raddr_i(rd_ptr_q),
        .rdata_o(data_out)
    );

endmodule

// File: tb/tb_vxe_fifo2.sv
// Directed bench for vxe_fifo2: one instance with empty1 enabled, one with it disabled.
module tb_vxe_fifo2;

    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic [31:0] data_in = '0;
    logic        wr = 1'b0;
    logic        rd = 1'b0;
    logic        srst = 1'b0;
    logic [31:0] data_out, data_out0;
    logic        full, empty1, empty;
    logic        full0, empty10, empty0;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    vxe_fifo2 #(
        .DATA_WIDTH(32),
        .DEPTH_POW2(2),
        .USE_EMPTY1(1)
    ) u_dut (
        .clk     (clk),
        .nrst    (nrst),
        .data_in (data_in),
        .data_out(data_out),
        .wr      (wr),
        .rd      (rd),
        .srst    (srst),
        .full    (full),
        .empty1  (empty1),
        .empty   (empty)
    );

    vxe_fifo2 #(
        .DATA_WIDTH(32),
        .DEPTH_POW2(2),
        .USE_EMPTY1(0)
    ) u_dut0 (
        .clk     (clk),
        .nrst    (nrst),
        .data_in (data_in),
        .data_out(data_out0),
        .wr      (wr),
        .rd      (rd),
        .srst    (srst),
        .full    (full0),
        .empty1  (empty10),
        .empty   (empty0)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled there too.
    task automatic cyc(input logic w, input logic r, input logic s, input logic [31:0] d);
        wr      = w;
        rd      = r;
        srst    = s;
        data_in = d;
        @(posedge clk);
        #1;
        wr   = 1'b0;
        rd   = 1'b0;
        srst = 1'b0;
    endtask

    task automatic flags(input string tag, input logic e, input logic f, input logic e1);
        chk({tag, ".empty"}, {31'd0, empty}, {31'd0, e});
        chk({tag, ".full"}, {31'd0, full}, {31'd0, f});
        chk({tag, ".empty1"}, {31'd0, empty1}, {31'd0, e1});
        chk({tag, ".empty1_off"}, {31'd0, empty10}, 32'd0);
    endtask

    initial begin
        // Reset state
        #2;
        flags("rst", 1'b1, 1'b0, 1'b0);
        chk("rst.data", data_out, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        nrst = 1'b1;

        // Fill / overflow
        cyc(1, 0, 0, 32'hBEEFCAFE);
        flags("fill1", 1'b0, 1'b0, 1'b1);
        chk("fill1.data", data_out, 32'hBEEFCAFE);
        cyc(1, 0, 0, 32'hBEEFCAFE);
        flags("fill2", 1'b0, 1'b0, 1'b0);
        cyc(1, 0, 0, 32'hBEEFCAFE);
        flags("fill3", 1'b0, 1'b0, 1'b0);
        cyc(1, 0, 0, 32'hBEEFCAFE);
        flags("fill4", 1'b0, 1'b1, 1'b0);
        cyc(1, 0, 0, 32'hBEEFCAFE);
        flags("fill5", 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("drain%0d.data", i), data_out, 32'hBEEFCAFE);
            cyc(0, 1, 0, 32'h0);
        end
        flags("drain4", 1'b1, 1'b0, 1'b0);
        cyc(0, 1, 0, 32'h0);
        flags("drain5", 1'b1, 1'b0, 1'b0);

        // Ordering with dropped fifth word
        for (int i = 1; i <= 5; i++) cyc(1, 0, 0, 32'hBEEF0000 + 32'(i));
        flags("ord.full", 1'b0, 1'b1, 1'b0);
        for (int i = 1; i <= 4; i++) begin
            chk($sformatf("ord%0d.data", i), data_out, 32'hBEEF0000 + 32'(i));
            cyc(0, 1, 0, 32'h0);
        end
        flags("ord.empty", 1'b1, 1'b0, 1'b0);

        // Simultaneous read/write from empty
        for (int i = 0; i < 5; i++) begin
            cyc(1, 1, 0, 32'hCAFECAFE);
            flags($sformatf("rw%0d", i), 1'b0, 1'b0, 1'b1);
            chk($sformatf("rw%0d.data", i), data_out, 32'hCAFECAFE);
        end
        cyc(0, 1, 0, 32'h0);
        flags("rw.end", 1'b1, 1'b0, 1'b0);

        // Read and write together while full
        for (int i = 1; i <= 4; i++) cyc(1, 0, 0, 32'(i));
        flags("fullrw.pre", 1'b0, 1'b1, 1'b0);
        chk("fullrw.pre.data", data_out, 32'd1);
        cyc(1, 1, 0, 32'd5);
        flags("fullrw.post", 1'b0, 1'b1, 1'b0);
        for (int i = 2; i <= 5; i++) begin
            chk($sformatf("fullrw%0d.data", i), data_out, 32'(i));
            cyc(0, 1, 0, 32'h0);
        end
        flags("fullrw.end", 1'b1, 1'b0, 1'b0);

        // Soft reset from full, then soft reset beating a write
        for (int i = 0; i < 5; i++) cyc(1, 0, 0, 32'hCAFEBEEF);
        flags("srst.pre", 1'b0, 1'b1, 1'b0);
        cyc(0, 0, 1, 32'h0);
        flags("srst.post", 1'b1, 1'b0, 1'b0);
        cyc(1, 1, 1, 32'hDEADDEAD);
        flags("srst.prio", 1'b1, 1'b0, 1'b0);
        cyc(1, 0, 0, 32'h12345678);
        flags("srst.wr", 1'b0, 1'b0, 1'b1);
        chk("srst.wr.data", data_out, 32'h12345678);
        cyc(0, 1, 0, 32'h0);
        flags("srst.rd", 1'b1, 1'b0, 1'b0);

        // Asynchronous reset in the middle of a fill
        cyc(1, 0, 0, 32'hA5A5A5A5);
        cyc(1, 0, 0, 32'h5A5A5A5A);
        flags("nrst.pre", 1'b0, 1'b0, 1'b0);
        nrst = 1'b0;
        #2;
        flags("nrst.async", 1'b1, 1'b0, 1'b0);
        chk("nrst.async.data", data_out, 32'h0);
        nrst = 1'b1;
        cyc(1, 0, 0, 32'h0BADF00D);
        flags("nrst.after", 1'b0, 1'b0, 1'b1);
        chk("nrst.after.data", data_out, 32'h0BADF00D);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
